// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline types for the forwarding/hazard controller:
// select codes, FSM state and the shadow stage record.
package fwd_hazard_ctrl_pkg;

    localparam int RAW = 5;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;
    localparam logic [1:0] FWD_ZERO = 2'd3;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
        logic           use_rs1;
        logic           use_rs2;
        logic [RAW-1:0] rd;
        logic           regwrite;
        logic           memread;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    function automatic logic writes_reg(
        input stage_t         s,
        input logic [RAW-1:0] r
    );
        return s.valid & s.regwrite & (s.rd == r);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Operand forward select for one EX source: x0 first,
// then the youngest writer (MEM ALU result, then WB).
module fwd_sel
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [RAW-1:0] src,
    input  logic           use_src,
    input  stage_t         mem,
    input  stage_t         wb,
    output logic [1:0]     sel
);

    logic zero_src;
    logic mem_hit;
    logic wb_hit;

    assign zero_src = (src == '0);
    // a load in MEM has no data yet, so it must not forward from there
    assign mem_hit  = writes_reg(mem, src) & ~mem.memread;
    assign wb_hit   = writes_reg(wb, src);

    always_comb begin
        sel = FWD_RF;
        priority case (1'b1)
            !use_src: sel = FWD_RF;
            zero_src: sel = FWD_ZERO;
            mem_hit:  sel = FWD_MEM;
            wb_hit:   sel = FWD_WB;
            default:  sel = FWD_RF;
        endcase
    end

    logic unused_fields;
    assign unused_fields = ^{mem.rs1, mem.rs2, mem.use_rs1, mem.use_rs2,
                             wb.rs1, wb.rs2, wb.use_rs1, wb.use_rs2,
                             wb.memread};

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller with a shadow
// EX/MEM/WB pipeline and a counted stall FSM.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = RAW,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              bubble
);

    localparam logic [1:0] CNT_LOAD = 2'(LOAD_STALL - 1);

    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;
    stage_t id_rec;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    logic hazard;
    logic advance;

    always_comb begin
        id_rec          = STAGE_EMPTY;
        id_rec.valid    = id_valid;
        id_rec.rs1      = id_rs1;
        id_rec.rs2      = id_rs2;
        id_rec.use_rs1  = id_use_rs1;
        id_rec.use_rs2  = id_use_rs2;
        id_rec.rd       = id_rd;
        id_rec.regwrite = id_regwrite;
        id_rec.memread  = id_memread;
    end

    assign hazard = id_valid & ex_q.valid & ex_q.memread
                  & ex_q.regwrite & (ex_q.rd != '0)
                  & ((id_use_rs1 & (id_rs1 == ex_q.rd))
                   | (id_use_rs2 & (id_rs2 == ex_q.rd)));

    assign advance = id_valid & (state_q == RUN)
                   & ~hazard & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= STAGE_EMPTY;
            mem_q <= STAGE_EMPTY;
            wb_q  <= STAGE_EMPTY;
        end else begin
            ex_q  <= advance ? id_rec : STAGE_EMPTY;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hazard) begin
                        cnt_d   = CNT_LOAD;
                        state_d = (LOAD_STALL > 1) ? HOLD : RUN;
                    end
                end
                HOLD: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // a redirect always wins over the stall, but still bubbles EX
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        unique case (state_q)
            RUN: begin
                stall  = hazard & ~flush;
                bubble = hazard | flush;
            end
            HOLD: begin
                stall  = ~flush;
                bubble = 1'b1;
            end
            default: begin
                stall  = 1'b0;
                bubble = 1'b0;
            end
        endcase
    end

    fwd_sel u_fwd_a (
        .src     (ex_q.rs1),
        .use_src (ex_q.valid & ex_q.use_rs1),
        .mem     (mem_q),
        .wb      (wb_q),
        .sel     (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src     (ex_q.rs2),
        .use_src (ex_q.valid & ex_q.use_rs2),
        .mem     (mem_q),
        .wb      (wb_q),
        .sel     (fwd_b)
    );

endmodule
